// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV64 datapath: walks each instruction through
// fetch/decode/execute/memory/write-back over one shared memory port.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [6:0]  opcode,
  input  logic        comp,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StBad    = 3'd7
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e      r_state, w_state_d;
  logic        r_illegal, w_illegal_d;
  logic [31:0] r_instr_count, w_instr_count_d;
  logic        w_retire;
  logic        w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br, w_legal;

  assign w_is_r  = (opcode == OpR);
  assign w_is_i  = (opcode == OpI);
  assign w_is_ld = (opcode == OpLoad);
  assign w_is_st = (opcode == OpStore);
  assign w_is_br = (opcode == OpBranch);
  assign w_legal = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br;

  // Outputs are gated by reset so strobes fall immediately, not on the next edge.
  always_comb begin
    w_state_d       = r_state;
    w_illegal_d     = r_illegal;
    w_instr_count_d = r_instr_count;
    w_retire        = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_sel         = 1'b0;
    ir_write        = 1'b0;
    mdr_write       = 1'b0;
    pc_write        = 1'b0;
    pc_src          = 1'b0;
    reg_write       = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src         = 1'b0;
    alu_op          = 2'b00;
    if (reset) begin
      unique case (r_state)
        StIdle: begin
          if (run) w_state_d = StFetch;
        end
        StFetch: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write  = 1'b1;
            w_state_d = StDecode;
          end
        end
        StDecode: begin
          if (!w_legal) begin
            w_state_d   = StHalt;
            w_illegal_d = 1'b1;
          end else begin
            w_state_d = StExec;
          end
        end
        StExec: begin
          alu_src = w_is_i | w_is_ld | w_is_st;
          if (w_is_br)     alu_op = 2'b01;
          else if (w_is_r) alu_op = 2'b10;
          else if (w_is_i) alu_op = 2'b11;
          if (w_is_br) begin
            pc_write = 1'b1;
            pc_src   = comp;
            w_retire = 1'b1;
          end else if (w_is_r || w_is_i) begin
            w_state_d = StWb;
          end else if (w_is_ld || w_is_st) begin
            w_state_d = StMem;
          end else begin
            w_state_d = StIdle;
          end
        end
        StMem: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = w_is_st;
          alu_src = 1'b1;
          if (mem_ack) begin
            if (w_is_st) begin
              pc_write = 1'b1;
              w_retire = 1'b1;
            end else begin
              mdr_write = 1'b1;
              w_state_d = StWb;
            end
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = w_is_ld;
          pc_write   = 1'b1;
          w_retire   = 1'b1;
        end
        StHalt: begin
          w_state_d = StHalt;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
      if (w_retire) begin
        w_instr_count_d = r_instr_count + 32'd1;
        w_state_d       = run ? StFetch : StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_illegal     <= 1'b0;
      r_instr_count <= 32'd0;
    end else begin
      r_state       <= w_state_d;
      r_illegal     <= w_illegal_d;
      r_instr_count <= w_instr_count_d;
    end
  end

  assign state       = r_state;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction vector table with a
// scoreboard queue, plus directed reset, halt, back-to-back and wrap sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset, run, comp, mem_ack;
  logic [6:0]  opcode;
  logic        mem_req, mem_we, mem_sel, ir_write, mdr_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .comp       (comp),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .ir_write   (ir_write),
    .mdr_write  (mdr_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .state      (state),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int       cycles;
    int       ir_w;
    int       mdr_w;
    int       reg_w;
    int       mem_cyc;
    logic [1:0] alu_op;
    logic     alu_src;
    logic     mem_we;
    logic     mem_to_reg;
    logic     pc_src;
    logic     fetch_sel;
  } res_t;

  typedef struct packed {
    logic [6:0] op;
    logic       comp;
    int         fw;
    int         mw;
    logic       keep_run;
    res_t       e;
  } vec_t;

  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic c, input int fw, input int mw,
                              input int cyc, input int mdr, input int rw, input int mc,
                              input logic [1:0] aop, input logic asrc, input logic we,
                              input logic m2r, input logic psrc);
    vec_t v;
    v = '0;
    v.op = op; v.comp = c; v.fw = fw; v.mw = mw; v.keep_run = 1'b0;
    v.e.cycles = cyc; v.e.ir_w = 1; v.e.mdr_w = mdr; v.e.reg_w = rw; v.e.mem_cyc = mc;
    v.e.alu_op = aop; v.e.alu_src = asrc; v.e.mem_we = we; v.e.mem_to_reg = m2r;
    v.e.pc_src = psrc; v.e.fetch_sel = 1'b0;
    return v;
  endfunction

  // Caller raises run beforehand; counting starts at the first FETCH cycle.
  task automatic exec_instr(input vec_t v, input string tag);
    res_t o;
    res_t e;
    int   fw, mw, cyc;
    bit   started, done;
    exp_q.push_back(v.e);
    o = '0; fw = v.fw; mw = v.mw; cyc = 0; started = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      opcode = v.op;
      comp   = v.comp;
      if (state == 3'd1) begin
        mem_ack = (fw == 0);
        if (fw > 0) fw--;
      end else if (state == 3'd4) begin
        mem_ack = (mw == 0);
        if (mw > 0) mw--;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      if (state == 3'd1) begin
        started = 1;
        run     = v.keep_run;
      end
      if (started) begin
        cyc++;
        if (ir_write) o.ir_w++;
        if (state == 3'd1 && mem_sel) o.fetch_sel = 1'b1;
        if (state == 3'd3) begin
          o.alu_op  = alu_op;
          o.alu_src = alu_src;
        end
        if (mem_req && mem_sel) o.mem_cyc++;
        if (mem_we) o.mem_we = 1'b1;
        if (mdr_write) o.mdr_w++;
        if (reg_write) begin
          o.reg_w++;
          o.mem_to_reg = mem_to_reg;
        end
        if (pc_write) begin
          o.pc_src = pc_src;
          o.cycles = cyc;
          done     = 1;
        end
      end
    end
    e = exp_q.pop_front();
    if (!done) begin
      check({tag, " retire timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " cycles"},     o.cycles,     e.cycles);
      check({tag, " ir_write"},   o.ir_w,       e.ir_w);
      check({tag, " fetch_sel"},  o.fetch_sel,  e.fetch_sel);
      check({tag, " mdr_write"},  o.mdr_w,      e.mdr_w);
      check({tag, " reg_write"},  o.reg_w,      e.reg_w);
      check({tag, " mem_cycles"}, o.mem_cyc,    e.mem_cyc);
      check({tag, " alu_op"},     o.alu_op,     e.alu_op);
      check({tag, " alu_src"},    o.alu_src,    e.alu_src);
      check({tag, " mem_we"},     o.mem_we,     e.mem_we);
      check({tag, " mem_to_reg"}, o.mem_to_reg, e.mem_to_reg);
      check({tag, " pc_src"},     o.pc_src,     e.pc_src);
    end
    @(posedge clk);
    #1;
    check({tag, " next_state"}, state, v.keep_run ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit   saw_pcw, saw_rw;
    vecs[0] = mk(7'b0110011, 0, 0, 0, 4, 0, 1, 0, 2'b10, 0, 0, 0, 0);  // R
    vecs[1] = mk(7'b0010011, 0, 1, 0, 5, 0, 1, 0, 2'b11, 1, 0, 0, 0);  // I-ALU, fetch wait
    vecs[2] = mk(7'b0000011, 0, 0, 2, 7, 1, 1, 3, 2'b00, 1, 0, 1, 0);  // LOAD, 2 mem waits
    vecs[3] = mk(7'b0100011, 0, 0, 0, 4, 0, 0, 1, 2'b00, 1, 1, 0, 0);  // STORE
    vecs[4] = mk(7'b1100011, 1, 0, 0, 3, 0, 0, 0, 2'b01, 0, 0, 0, 1);  // BRANCH taken
    vecs[5] = mk(7'b1100011, 0, 0, 0, 3, 0, 0, 0, 2'b01, 0, 0, 0, 0);  // BRANCH not taken
    vecs[6] = mk(7'b0100011, 0, 2, 1, 7, 0, 0, 2, 2'b00, 1, 1, 0, 0);  // STORE, waits

    reset = 1'b0; run = 1'b0; comp = 1'b0; mem_ack = 1'b1; opcode = 7'b0110011;
    #23;
    check("reset state", state, 32'd0);
    check("reset illegal", illegal, 32'd0);
    check("reset count", instr_count, 32'd0);
    run = 1'b1;
    #1;
    check("reset mem_req", mem_req, 32'd0);
    check("reset pc_write", pc_write, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      run = 1'b1;
      exec_instr(vecs[i], $sformatf("vec%0d", i));
    end
    check("count after table", instr_count, 32'd7);

    // Back-to-back: run held through retire, no IDLE bubble.
    v = vecs[0];
    v.keep_run = 1'b1;
    @(negedge clk);
    run = 1'b1;
    exec_instr(v, "b2b_first");
    exec_instr(vecs[0], "b2b_second");
    check("count after b2b", instr_count, 32'd9);

    // Asynchronous reset in the middle of an outstanding fetch.
    @(negedge clk);
    run = 1'b1; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    check("fetch entered", state, 32'd1);
    check("fetch mem_req", mem_req, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midreset state", state, 32'd0);
    check("midreset mem_req", mem_req, 32'd0);
    check("midreset count", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("release to fetch", state, 32'd1);
    exec_instr(vecs[0], "after_reset");

    // Unsupported opcode halts permanently.
    saw_pcw = 0; saw_rw = 0;
    @(negedge clk);
    run = 1'b1;
    for (int k = 0; k < 10 && state != 3'd6; k++) begin
      @(negedge clk);
      opcode  = 7'b1111111;
      mem_ack = 1'b1;
      #1;
      if (state == 3'd1) run = 1'b0;
      if (pc_write) saw_pcw = 1;
      if (reg_write) saw_rw = 1;
    end
    check("halt state", state, 32'd6);
    check("halt illegal", illegal, 32'd1);
    check("halt no pc_write", saw_pcw, 32'd0);
    check("halt no reg_write", saw_rw, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      run = ~run;
      #1;
      if (pc_write || reg_write || mem_req) saw_pcw = 1;
    end
    check("halt held", state, 32'd6);
    check("halt sticky", illegal, 32'd1);
    check("halt quiet", saw_pcw, 32'd0);
    run = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("halt cleared", illegal, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Counter wrap on a STORE retire, then run=0 returns to IDLE.
    @(negedge clk);
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_instr_count;
    #1;
    check("preload count", instr_count, 32'hFFFF_FFFF);
    run = 1'b1;
    exec_instr(vecs[3], "wrap_store");
    check("wrap count", instr_count, 32'd0);
    check("wrap mem_req", mem_req, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
